pipelined_adder_v: RTL and testbench

// - Parametrised, pipelined WIDTH-bit adder with carry-in, carry-out and signed overflow.
// - Successor to the single-bit full adder: the operand is split into STAGES equal slices.

---
 rtl/pipelined_adder_v_pkg.sv | 20 ++
 rtl/adder_slice_v.sv | 19 +
 rtl/full_adder_v.sv | 11 +
 rtl/pipelined_adder_v.sv | 88 ++++++++
 tb/tb_pipelined_adder_v.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_v_pkg.sv
// pipelined_adder_v_pkg: default geometry, slice-width helper and reference result for the pipelined adder
package pipelined_adder_v_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] s;
    logic c;
    logic v;
  } res_t;
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic res_t ref_add(input logic [DEF_WIDTH-1:0] a, input logic [DEF_WIDTH-1:0] b, input logic cin);
    logic [DEF_WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b} + {{DEF_WIDTH{1'b0}}, cin};
    ref_add.s = t[DEF_WIDTH-1:0];
    ref_add.c = t[DEF_WIDTH];
    ref_add.v = (a[DEF_WIDTH-1] == b[DEF_WIDTH-1]) && (t[DEF_WIDTH-1] != a[DEF_WIDTH-1]);
  endfunction
endpackage

// File: rtl/adder_slice_v.sv
// adder_slice_v: W-bit ripple of full adders, also exposing the carry into the top bit
module adder_slice_v #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder_v u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  assign cout = c[W];
  assign c_msb_in = c[W-1];
endmodule

// File: rtl/full_adder_v.sv
// full_adder_v: single-bit full adder
module full_adder_v (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_adder_v.sv
// pipelined_adder_v: STAGES-deep slice-per-stage adder with valid/ready handshake and bubble collapsing
module pipelined_adder_v
  import pipelined_adder_v_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_valid,
  input  logic             i_ready
);
  localparam int SLICE = slice_w(WIDTH, STAGES);
  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_geometry
    $error("pipelined_adder_v: WIDTH must be >= 2 and an exact multiple of STAGES (1..WIDTH)");
  end
  logic             v_r  [STAGES];
  logic             c_r  [STAGES];
  logic             ov_r [STAGES];
  logic             ld   [STAGES];
  logic [WIDTH-1:0] a_r  [STAGES];
  logic [WIDTH-1:0] b_r  [STAGES];
  logic [WIDTH-1:0] s_r  [STAGES];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_in, b_in, s_in, s_n;
    logic [SLICE-1:0] sl_s;
    logic             cin, take, co, cm;
    // Operands travel pre-shifted so every stage adds the low SLICE bits it receives.
    if (k == 0) begin : g_head
      assign a_in = i_a;
      assign b_in = i_b;
      assign s_in = '0;
      assign cin = i_carry;
      assign take = i_valid;
    end else begin : g_body
      assign a_in = a_r[k-1];
      assign b_in = b_r[k-1];
      assign s_in = s_r[k-1];
      assign cin = c_r[k-1];
      assign take = v_r[k-1];
    end
    if (k == STAGES - 1) begin : g_last
      assign ld[k] = !v_r[k] || i_ready;
    end else begin : g_mid
      assign ld[k] = !v_r[k] || ld[k+1];
    end
    adder_slice_v #(.W(SLICE)) u_slice (
      .a(a_in[SLICE-1:0]), .b(b_in[SLICE-1:0]), .cin(cin),
      .s(sl_s), .cout(co), .c_msb_in(cm)
    );
    always_comb begin
      s_n = s_in;
      s_n[k*SLICE +: SLICE] = sl_s;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        ov_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end else if (ld[k]) begin
        v_r[k] <= take;
        if (take) begin
          c_r[k] <= co;
          ov_r[k] <= cm ^ co;
          a_r[k] <= a_in >> SLICE;
          b_r[k] <= b_in >> SLICE;
          s_r[k] <= s_n;
        end
      end
    end
  end
  assign o_ready = ld[0];
  assign o_valid = v_r[STAGES-1];
  assign o_s = s_r[STAGES-1];
  assign o_carry = c_r[STAGES-1];
  assign o_overflow = ov_r[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder_v.sv
// tb_pipelined_adder_v: directed and randomised checks of the pipelined adder against hand values and ref_add
module tb_pipelined_adder_v;
  import pipelined_adder_v_pkg::*;
  localparam int W = DEF_WIDTH;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         i_carry = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic         o_ready, o_carry, o_overflow, o_valid;
  logic [W-1:0] o_s;
  pipelined_adder_v #(.WIDTH(W), .STAGES(DEF_STAGES)) dut (
    .i_clk(clk), .i_rst(rst), .i_a(i_a), .i_b(i_b), .i_carry(i_carry), .i_valid(i_valid),
    .o_ready(o_ready), .o_s(o_s), .o_carry(o_carry), .o_overflow(o_overflow),
    .o_valid(o_valid), .i_ready(i_ready)
  );
  always #5 clk = ~clk;
  int   n_chk = 0, n_ok = 0, n_out = 0, cyc = 0, last_lat = 0, waited = 0;
  res_t cur_exp, e;
  res_t exp_q[$];
  int   in_q[$];
  int   oc[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic v);
    mk.s = s;
    mk.c = c;
    mk.v = v;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) if (!rst) begin
    if (i_valid && o_ready) begin
      exp_q.push_back(cur_exp);
      in_q.push_back(cyc);
    end
    if (o_valid && i_ready) begin
      n_out++;
      oc.push_back(cyc);
      check("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_lat = cyc - in_q.pop_front();
        check("sum", 32'(o_s), 32'(e.s));
        check("carry", 32'(o_carry), 32'(e.c));
        check("overflow", 32'(o_overflow), 32'(e.v));
      end
    end
  end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input res_t ex, output int wt);
    bit acc;
    acc = 1'b0;
    wt = 0;
    i_a = a;
    i_b = b;
    i_carry = c;
    cur_exp = ex;
    i_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      wt++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    i_valid = 1'b0;
  endtask
  task automatic wait_out(input int target);
    for (int k = 0; k < 500 && n_out < target; k++) @(posedge clk);
    #1;
    check("out_count", 32'(n_out), 32'(target));
  endtask
  logic [W-1:0] b2b_s [8] = '{16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656, 16'h6767, 16'h7878, 16'h8989};
  initial begin
    int n0, acc_n;
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_s", 32'(o_s), 32'd0);
    check("rst_carry", 32'(o_carry), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), waited);
    wait_out(1);
    check("latency", 32'(last_lat), 32'd4);
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), waited);
    send(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1), waited);
    wait_out(3);
    send(16'h1234, 16'h0000, 1'b1, mk(16'h1235, 1'b0, 1'b0), waited);
    wait_out(4);
    for (int i = 0; i < 8; i++) begin
      send(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, mk(b2b_s[i], 1'b0, 1'b0), waited);
      check("b2b_ready", 32'(waited), 32'd0);
    end
    wait_out(12);
    for (int k = 5; k < 12; k++) check("b2b_consecutive", 32'(oc[k] - oc[k-1]), 32'd1);
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(16'(i), 16'h1000, 1'b0, mk(16'h1000 + 16'(i), 1'b0, 1'b0), waited);
      check("stall_fill", 32'(waited), 32'd0);
    end
    check("stall_ready_low", 32'(o_ready), 32'd0);
    check("stall_valid", 32'(o_valid), 32'd1);
    check("stall_s", 32'(o_s), 32'h1001);
    repeat (2) @(posedge clk);
    #1;
    check("stall_ready_held", 32'(o_ready), 32'd0);
    check("stall_s_held", 32'(o_s), 32'h1001);
    check("stall_no_out", 32'(n_out), 32'd12);
    i_ready = 1'b1;
    for (int i = 5; i <= 10; i++) send(16'(i), 16'h1000, 1'b0, mk(16'h1000 + 16'(i), 1'b0, 1'b0), waited);
    wait_out(22);
    check("stall_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i), 1'b0, mk(16'(2 * i), 1'b0, 1'b0), waited);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    in_q.delete();
    #1;
    check("async_valid", 32'(o_valid), 32'd0);
    check("async_s", 32'(o_s), 32'd0);
    check("async_carry", 32'(o_carry), 32'd0);
    check("async_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    n0 = n_out;
    repeat (8) @(posedge clk);
    #1;
    check("no_stale", 32'(n_out), 32'(n0));
    send(16'h0005, 16'h0003, 1'b1, mk(16'h0009, 1'b0, 1'b0), waited);
    wait_out(n0 + 1);
    check("post_rst_latency", 32'(last_lat), 32'd4);
    n0 = n_out;
    acc_n = 0;
    while (acc_n < 10000) begin
      i_a = W'($urandom);
      i_b = W'($urandom);
      i_carry = 1'($urandom);
      i_valid = $urandom_range(3) != 0;
      i_ready = $urandom_range(3) != 0;
      cur_exp = ref_add(i_a, i_b, i_carry);
      @(negedge clk);
      if (i_valid && o_ready) acc_n++;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_out(n0 + acc_n);
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
